// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one 8-bit alu between two valid/ready requesters.
// state | meaning: IDLE wait/grant request, EXEC hold alu operands, RESP present result
module alu_scheduler #(
  parameter int unsigned FAST_LAT = 1,
  parameter int unsigned SLOW_LAT = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req_valid,
  output logic [1:0] o_req_ready,
  input  logic [7:0] i_req_a0,
  input  logic [7:0] i_req_b0,
  input  logic [3:0] i_req_op0,
  input  logic [7:0] i_req_a1,
  input  logic [7:0] i_req_b1,
  input  logic [3:0] i_req_op1,
  output logic [1:0] o_rsp_valid,
  input  logic [1:0] i_rsp_ready,
  output logic [7:0] o_rsp_result,
  output logic [7:0] o_rsp_flags,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [3:0] o_alu_op,
  input  logic [7:0] i_alu_resultado,
  input  logic [7:0] i_alu_flags,
  output logic       o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] FAST_LOAD = 4'(FAST_LAT - 1);
  localparam logic [3:0] SLOW_LOAD = 4'(SLOW_LAT - 1);

  state_t      r_state;
  logic        r_grant;
  logic        r_last_grant;
  logic [3:0]  r_cnt;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [3:0]  r_alu_op;
  logic [7:0]  r_rsp_result;
  logic [7:0]  r_rsp_flags;
  logic [1:0]  r_rsp_valid;

  logic        w_grant;
  logic [1:0]  w_req_ready;
  logic        w_accept;
  logic [7:0]  w_sel_a;
  logic [7:0]  w_sel_b;
  logic [3:0]  w_sel_op;
  logic        w_slow;

  // Alternate only on a tie; a lone requester always wins.
  assign w_grant     = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];
  assign w_req_ready = (r_state == S_IDLE) ? (i_req_valid & (w_grant ? 2'b10 : 2'b01)) : 2'b00;
  assign w_accept    = |w_req_ready;
  assign w_sel_a     = w_grant ? i_req_a1  : i_req_a0;
  assign w_sel_b     = w_grant ? i_req_b1  : i_req_b0;
  assign w_sel_op    = w_grant ? i_req_op1 : i_req_op0;
  assign w_slow      = (w_sel_op == 4'b1000) || (w_sel_op == 4'b1001) || (w_sel_op == 4'b1010);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_alu_a      <= 8'd0;
      r_alu_b      <= 8'd0;
      r_alu_op     <= 4'd0;
      r_rsp_result <= 8'd0;
      r_rsp_flags  <= 8'd0;
      r_rsp_valid  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op     <= w_sel_op;
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= w_slow ? SLOW_LOAD : FAST_LOAD;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_result <= i_alu_resultado;
            r_rsp_flags  <= i_alu_flags;
            r_rsp_valid  <= r_grant ? 2'b10 : 2'b01;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready[r_grant]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_op     = r_alu_op;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: directed requests, queue of hand-computed responses.
module tb_alu_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] i_req_valid = 2'b00;
  logic [1:0] o_req_ready;
  logic [7:0] i_req_a0 = 8'd0, i_req_b0 = 8'd0, i_req_a1 = 8'd0, i_req_b1 = 8'd0;
  logic [3:0] i_req_op0 = 4'd0, i_req_op1 = 4'd0;
  logic [1:0] o_rsp_valid;
  logic [1:0] i_rsp_ready = 2'b11;
  logic [7:0] o_rsp_result, o_rsp_flags, o_alu_a, o_alu_b;
  logic [3:0] o_alu_op;
  logic [7:0] i_alu_resultado, i_alu_flags;
  logic       o_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       port;
    logic [7:0] res;
    logic [7:0] flg;
  } exp_t;
  exp_t sb[$];

  alu_scheduler #(.FAST_LAT(1), .SLOW_LAT(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a0(i_req_a0), .i_req_b0(i_req_b0), .i_req_op0(i_req_op0),
    .i_req_a1(i_req_a1), .i_req_b1(i_req_b1), .i_req_op1(i_req_op1),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_flags(o_rsp_flags),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_resultado(i_alu_resultado), .i_alu_flags(i_alu_flags),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural alu stand-in; flags are {N,Z,C,P,0,0,0,0} with P = odd parity.
  logic [7:0] alu_r;
  logic       alu_c;
  always_comb begin
    alu_r = 8'd0;
    alu_c = 1'b0;
    case (o_alu_op)
      4'b0000: {alu_c, alu_r} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
      4'b0010: alu_r = o_alu_a & o_alu_b;
      4'b1000: alu_r = 8'(o_alu_a * o_alu_b);
      4'b1001: alu_r = (o_alu_b == 8'd0) ? 8'hFF : o_alu_a / o_alu_b;
      4'b1010: alu_r = (o_alu_b == 8'd0) ? o_alu_a : o_alu_a % o_alu_b;
      4'b1110, 4'b1111: alu_r = 8'd0;
      default: alu_r = o_alu_a | o_alu_b;
    endcase
  end
  assign i_alu_resultado = alu_r;
  assign i_alu_flags     = {alu_r[7], (alu_r == 8'd0), alu_c, ^alu_r, 4'b0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rsp_valid == 2'b11) chk("rsp_valid_onehot", {30'd0, o_rsp_valid}, 32'h1);
      for (int p = 0; p < 2; p++) begin
        if (o_rsp_valid[p] && i_rsp_ready[p]) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp_port", p, 32'hFFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_port", p, {31'd0, e.port});
            chk("rsp_result", {24'd0, o_rsp_result}, {24'd0, e.res});
            chk("rsp_flags", {24'd0, o_rsp_flags}, {24'd0, e.flg});
          end
        end
      end
    end
  end

  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.port = p; e.res = r; e.flg = f;
    sb.push_back(e);
  endtask

  task automatic drive(input logic p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if (p) begin i_req_a1 = a; i_req_b1 = b; i_req_op1 = op; end
    else   begin i_req_a0 = a; i_req_b0 = b; i_req_op0 = op; end
    i_req_valid[p] = 1'b1;
  endtask

  task automatic wait_acc(input logic p);
    bit ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge i_clk);
      if (o_req_ready[p] && i_req_valid[p]) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge i_clk); #1;
    i_req_valid[p] = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns EXEC cycles until rsp_valid[p].
  task automatic wait_rsp(input logic p, input logic [3:0] op, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      if (o_busy && o_rsp_valid == 2'b00) chk("alu_op_hold", {28'd0, o_alu_op}, {28'd0, op});
      if (o_rsp_valid[p]) break;
      @(posedge i_clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge i_clk);
      if (!o_busy && o_rsp_valid == 2'b00 && sb.size() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int cnt0, cnt1;
    logic [1:0] hs;

    // Reset values
    #3;
    chk("rst_req_ready", {30'd0, o_req_ready}, 0);
    chk("rst_rsp_valid", {30'd0, o_rsp_valid}, 0);
    chk("rst_result", {24'd0, o_rsp_result}, 0);
    chk("rst_flags", {24'd0, o_rsp_flags}, 0);
    chk("rst_alu", {12'd0, o_alu_a, o_alu_b, o_alu_op}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    do_reset();

    // 1: port 0 add
    push(1'b0, 8'h10, 8'h10);
    drive(1'b0, 8'h0F, 8'h01, 4'b0000);
    wait_acc(1'b0);
    wait_rsp(1'b0, 4'b0000, cyc);
    chk("t1_latency", cyc, 1);
    wait_idle();

    // 2: port 1 div, slow latency
    push(1'b1, 8'd3, 8'h00);
    drive(1'b1, 8'd10, 8'd3, 4'b1001);
    wait_acc(1'b1);
    wait_rsp(1'b1, 4'b1001, cyc);
    chk("t2_latency", cyc, 3);
    wait_idle();

    // 4: response stalled 5 cycles, port 1 waiting meanwhile
    i_rsp_ready = 2'b10;
    push(1'b0, 8'h00, 8'h60);
    drive(1'b0, 8'hFF, 8'h01, 4'b0000);
    wait_acc(1'b0);
    wait_rsp(1'b0, 4'b0000, cyc);
    chk("t4_latency", cyc, 1);
    push(1'b1, 8'h07, 8'h10);
    drive(1'b1, 8'h0F, 8'h07, 4'b0010);
    repeat (5) begin
      @(negedge i_clk);
      chk("t4_result", {24'd0, o_rsp_result}, 32'h00);
      chk("t4_flags", {24'd0, o_rsp_flags}, 32'h60);
      chk("t4_req_ready", {30'd0, o_req_ready}, 0);
      chk("t4_rsp_valid", {30'd0, o_rsp_valid}, 1);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b11;
    wait_acc(1'b1);
    wait_idle();

    // 6: div by zero, port 1 blocked during port 0 RESP
    i_rsp_ready = 2'b10;
    push(1'b0, 8'hFF, 8'h80);
    drive(1'b0, 8'h22, 8'h00, 4'b1001);
    wait_acc(1'b0);
    wait_rsp(1'b0, 4'b1001, cyc);
    chk("t6_latency", cyc, 3);
    push(1'b1, 8'hFF, 8'h80);
    drive(1'b1, 8'h22, 8'h00, 4'b1001);
    repeat (2) begin
      @(negedge i_clk);
      chk("t6_req_ready", {30'd0, o_req_ready}, 0);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b11;
    @(negedge i_clk);
    chk("t6_req_ready_hs", {30'd0, o_req_ready}, 0);
    wait_acc(1'b1);
    wait_idle();

    // 5: reset during EXEC of mul drops the op
    drive(1'b0, 8'd3, 8'd4, 4'b1000);
    wait_acc(1'b0);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", {30'd0, o_rsp_valid}, 0);
    chk("t5_result", {24'd0, o_rsp_result}, 0);
    chk("t5_flags", {24'd0, o_rsp_flags}, 0);
    chk("t5_alu", {12'd0, o_alu_a, o_alu_b, o_alu_op}, 0);
    chk("t5_busy", {31'd0, o_busy}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      chk("t5_no_rsp", {30'd0, o_rsp_valid}, 0);
    end
    @(posedge i_clk); #1;
    push(1'b0, 8'h08, 8'h10);
    push(1'b1, 8'h00, 8'h40);
    drive(1'b0, 8'h05, 8'h03, 4'b0000);
    drive(1'b1, 8'h12, 8'h34, 4'b1110);
    #1;
    chk("t5_tie_grant", {30'd0, o_req_ready}, 1);
    wait_acc(1'b0);
    wait_acc(1'b1);
    wait_idle();

    // 3: both ports valid continuously from reset; grants alternate 0,1,...
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 8'h30, 8'h00);
      push(1'b1, 8'h07, 8'h10);
    end
    drive(1'b0, 8'hF0, 8'h3C, 4'b0010);
    drive(1'b1, 8'h0F, 8'h07, 4'b0010);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 200 && (cnt0 + cnt1) < 8; k++) begin
      @(negedge i_clk);
      hs = i_req_valid & o_req_ready;
      @(posedge i_clk); #1;
      if (hs[0]) cnt0++;
      if (hs[1]) cnt1++;
      if (cnt0 >= 4) i_req_valid[0] = 1'b0;
      if (cnt1 >= 4) i_req_valid[1] = 1'b0;
    end
    chk("t3_port0_grants", cnt0, 4);
    chk("t3_port1_grants", cnt1, 4);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
